reg_mem_mp: RTL and testbench

- Parametrised successor to the single-port register memory.
- One synchronous write port and NUM_RD independent registered read ports.
- Configurable depth, with out-of-range address detection.
- Built-in clear sequencer zeroes every entry after reset or on request. Used as the shared scratch/register file between tutorial datapath blocks.

---
 rtl/reg_mem_mp.sv | 103 ++++++++++
 tb/tb_reg_mem_mp.sv | 132 +++++++++++++
 2 files changed

// File: rtl/reg_mem_mp.sv
// reg_mem_mp: register memory with one write port, NUM_RD registered read ports and a clear sequencer
module reg_mem_mp #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_BITS   = 5,
  parameter int DEPTH       = 24,
  parameter int NUM_RD      = 2,
  parameter int WRITE_FIRST = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         wen,
  input  logic [ADDR_BITS-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic [NUM_RD-1:0]            ren,
  input  logic [NUM_RD*ADDR_BITS-1:0]  raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
  output logic [NUM_RD-1:0]            rvalid,
  output logic [NUM_RD-1:0]            rerr,
  output logic                         werr,
  output logic                         busy
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic {CLEAR, READY} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] clr_ptr_q, clr_ptr_d;
  logic busy_q, busy_d, werr_q, werr_d;
  logic [NUM_RD-1:0] rvalid_q, rvalid_d, rerr_q, rerr_d;
  logic [NUM_RD*DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic mem_we, wr_ok;
  logic [ADDR_BITS-1:0] mem_addr, ra;
  logic [DATA_WIDTH-1:0] mem_wdata;
  assign wr_ok = 32'(waddr) < DEPTH;
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    busy_d    = busy_q;
    werr_d    = 1'b0;
    rvalid_d  = '0;
    rerr_d    = '0;
    rdata_d   = rdata_q;
    mem_we    = 1'b0;
    mem_addr  = ADDR_BITS'(clr_ptr_q);
    mem_wdata = '0;
    ra        = '0;
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      clr_ptr_d = 32'(clr_ptr_q) == DEPTH - 1 ? '0 : clr_ptr_q + 1'b1;
      state_d   = 32'(clr_ptr_q) == DEPTH - 1 ? READY : CLEAR;
      busy_d    = 32'(clr_ptr_q) != DEPTH - 1;
    end else begin
      if (clr) begin
        state_d   = CLEAR;
        clr_ptr_d = '0;
        busy_d    = 1'b1;
      end
      if (wen) begin
        mem_we    = wr_ok;
        mem_addr  = waddr;
        mem_wdata = wdata;
        werr_d    = !wr_ok;
      end
      for (int i = 0; i < NUM_RD; i++) begin
        ra = raddr[i*ADDR_BITS +: ADDR_BITS];
        if (ren[i]) begin
          rvalid_d[i] = 1'b1;
          rerr_d[i]   = !(32'(ra) < DEPTH);
          rdata_d[i*DATA_WIDTH +: DATA_WIDTH] = rerr_d[i] ? '0 :
            (WRITE_FIRST != 0 && wen && waddr == ra) ? wdata : mem[ra];
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      busy_q    <= 1'b1;
      werr_q    <= 1'b0;
      rvalid_q  <= '0;
      rerr_q    <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      busy_q    <= busy_d;
      werr_q    <= werr_d;
      rvalid_q  <= rvalid_d;
      rerr_q    <= rerr_d;
      rdata_q   <= rdata_d;
    end
  end
  // Storage is not reset; the clear sequence zeroes it instead.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_addr] <= mem_wdata;
  end
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign rerr   = rerr_q;
  assign werr   = werr_q;
  assign busy   = busy_q;
endmodule

// File: tb/tb_reg_mem_mp.sv
// tb_reg_mem_mp: directed plan plus random traffic against a behavioural model of reg_mem_mp
module tb_reg_mem_mp;
  localparam int DW = 8, AB = 5, D = 24, NR = 2, WF = 1;
  logic clk = 0, rst = 0, clr = 0, wen = 0;
  logic [AB-1:0] waddr = '0;
  logic [DW-1:0] wdata = '0;
  logic [NR-1:0] ren = '0;
  logic [NR*AB-1:0] raddr = '0;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0] rvalid, rerr;
  logic werr, busy;
  reg_mem_mp #(.DATA_WIDTH(DW), .ADDR_BITS(AB), .DEPTH(D), .NUM_RD(NR), .WRITE_FIRST(WF)) dut (
    .clk(clk), .rst(rst), .clr(clr), .wen(wen), .waddr(waddr), .wdata(wdata),
    .ren(ren), .raddr(raddr), .rdata(rdata), .rvalid(rvalid), .rerr(rerr),
    .werr(werr), .busy(busy)
  );
  always #5 clk = ~clk;
  logic [DW-1:0] m_mem [D];
  logic [DW-1:0] e_rdata [NR];
  logic [NR-1:0] e_rvalid, e_rerr;
  logic e_werr, e_busy;
  int m_left = 0, total = 0, bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  // Model: m_left counts remaining clear cycles; memory reads as zero once it reaches 0.
  task automatic step();
    int a;
    if (rst) begin
      m_left = D; e_busy = 1; e_werr = 0; e_rvalid = 0; e_rerr = 0;
      for (int i = 0; i < NR; i++) e_rdata[i] = 0;
    end else if (m_left > 0) begin
      m_left--; e_busy = m_left > 0; e_werr = 0; e_rvalid = 0; e_rerr = 0;
      if (m_left == 0) for (int j = 0; j < D; j++) m_mem[j] = 0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        e_rvalid[i] = ren[i]; e_rerr[i] = 0;
        if (ren[i]) begin
          a = int'(raddr[i*AB +: AB]);
          if (a >= D) begin e_rerr[i] = 1; e_rdata[i] = 0; end
          else e_rdata[i] = (WF != 0 && wen && int'(waddr) == a) ? wdata : m_mem[a];
        end
      end
      e_werr = wen && int'(waddr) >= D;
      if (wen && int'(waddr) < D) m_mem[waddr] = wdata;
      if (clr) begin m_left = D; e_busy = 1; end
    end
    @(posedge clk); #1;
    chk("busy", busy, e_busy);
    chk("werr", werr, e_werr);
    for (int i = 0; i < NR; i++) begin
      chk($sformatf("rvalid%0d", i), rvalid[i], e_rvalid[i]);
      chk($sformatf("rerr%0d", i), rerr[i], e_rerr[i]);
      chk($sformatf("rdata%0d", i), rdata[i*DW +: DW], e_rdata[i]);
    end
  endtask
  task automatic idle();
    rst = 0; clr = 0; wen = 0; ren = '0;
  endtask
  task automatic wr(input int a, input int d);
    wen = 1; waddr = AB'(a); wdata = DW'(d); step(); wen = 0;
  endtask
  task automatic rd2(input int a0, input int a1);
    ren = 2'b11; raddr = {AB'(a1), AB'(a0)}; step(); ren = '0;
  endtask
  task automatic count_busy(input string tag);
    int n = 0;
    while (busy && n < 100) begin n++; step(); end
    chk(tag, n, D);
  endtask
  initial begin
    #1;
    idle(); rst = 1; step(); rst = 0;
    chk("reset_rdata", rdata, 0);
    count_busy("busy_len_reset");
    for (int i = 0; i < D; i++) rd2(i, i);
    for (int i = 10; i <= 21; i++) wr(i + 2, i);
    for (int k = 0; k < 12; k++) rd2(12 + k, 23 - k);
    wr(5, 8'hAA);
    wen = 1; waddr = 5; wdata = 8'h55; ren = 2'b01; raddr = {AB'(0), AB'(5)};
    step(); idle();
    chk("collision", rdata[DW-1:0], WF != 0 ? 8'h55 : 8'hAA);
    rd2(5, 5);
    chk("after_coll", rdata[DW-1:0], 8'h55);
    wr(30, 8'h77);
    chk("werr_pulse", werr, 1);
    step();
    chk("werr_clear", werr, 0);
    ren = 2'b10; raddr = {AB'(30), AB'(0)}; step(); idle();
    chk("oor_rdata1", rdata[2*DW-1:DW], 0);
    chk("oor_rerr1", rerr[1], 1);
    wr(12, 8'h12);
    clr = 1; wen = 1; waddr = 3; wdata = 8'h33; step(); idle();
    chk("clr_busy", busy, 1);
    begin
      int n = 0;
      while (busy && n < 100) begin
        n++; wen = 1; waddr = AB'($urandom_range(0, D - 1)); wdata = DW'($urandom);
        ren = NR'($urandom); raddr = NR*AB'($urandom); step();
      end
      idle();
      chk("busy_len_clr", n, D);
    end
    rd2(3, 12);
    chk("clr_addr3", rdata[DW-1:0], 0);
    chk("clr_addr12", rdata[2*DW-1:DW], 0);
    wr(7, 8'h99);
    clr = 1; step(); clr = 0;
    for (int i = 0; i < 9; i++) step();
    rst = 1; step(); rst = 0;
    count_busy("busy_len_rst_mid");
    rd2(7, 7);
    chk("rst_mid_zero", rdata[DW-1:0], 0);
    for (int c = 0; c < 1500; c++) begin
      rst = $urandom_range(0, 299) == 0;
      clr = $urandom_range(0, 99) == 0;
      wen = $urandom_range(0, 1) == 1;
      waddr = AB'($urandom_range(0, 31));
      wdata = DW'($urandom);
      ren = NR'($urandom);
      raddr = {AB'($urandom_range(0, 31)), AB'($urandom_range(0, 31))};
      step();
    end
    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
